regfile_wb_writer: RTL and testbench
====================================

// Module: regfile_wb_writer
// PURPOSE
// - Write side of the 3-port register file: produces wb_q_is_rd_write / wb_rd_addr / wb_rd_wdata.
// - Merges in-order MEM-stage results (priority) with out-of-order long-latency results (MDU) buffered in a FIFO.
// - Prevents FIFO starvation by stalling MEM for one cycle; exports a per-register busy mask for ID hazard checks.
// PARAMETERS
// - FIFO_DEPTH   4   MDU result buffer entries (power of 2, >=2)
// - STARVE_LIMIT 8   consecutive denied cycles (FIFO non-empty, MEM writing) before a forced drain
// PORTS
// - clk_i              in   1   clock
// - rst_i              in   1   synchronous, active-high reset
// - mem_valid_i        in   1   MEM-stage result valid
// - mem_ready_o        out  1   MEM result accepted this cycle
// - mem_is_rd_write_i  in   1   MEM result writes rd
// - mem_rd_addr_i      in   5   MEM destination register
// - mem_rd_wdata_i     in   32  MEM write data
// - mdu_valid_i        in   1   MDU result valid
// - mdu_ready_o        out  1   MDU result accepted (FIFO not full)
// - mdu_rd_addr_i      in   5   MDU destination register
// - mdu_rd_wdata_i     in   32  MDU write data
// - rd_busy_o          out  32  bit n = a FIFO entry targets xn (bit 0 always 0)
// - wb_q_is_rd_write   out  1   registered write enable to regfile
// - wb_rd_addr         out  5   registered write address
// - wb_rd_wdata        out  32  registered write data
// BEHAVIOUR
// - Reset: all outputs 0 except mem_ready_o=1 and mdu_ready_o=1; FIFO empty; starve_cnt=0; state NORMAL.
// - Handshake: a transfer occurs when valid && ready; valid is never gated by ready.
// - Latency: an accepted result appears on the wb_* outputs the following cycle, held for 1 cycle.
// - States: NORMAL, DRAIN.
//   NORMAL: mem_ready_o=1. MEM write (mem_valid_i && mem_is_rd_write_i) owns the output slot;
//           otherwise the FIFO head is popped into the slot. MEM valid without rd write does not occupy the slot.
//   starve_cnt increments when FIFO is non-empty and a MEM write wins; clears on any pop.
//   starve_cnt == STARVE_LIMIT-1 with another denial -> DRAIN next cycle.
//   DRAIN: mem_ready_o=0 for exactly 1 cycle; FIFO head popped; starve_cnt cleared; return to NORMAL.
// - FIFO: mdu_ready_o = !full. A push and a pop in the same cycle are both legal when full (pop frees the slot):
//   mdu_ready_o is still 0 in that cycle (registered full flag, no combinational ready path).
// - x0: any write with rd_addr==0 is accepted and consumed but drives wb_q_is_rd_write=0.
//   MDU writes to x0 are never pushed into the FIFO.
// - rd_busy_o: OR of one-hot(rd_addr) over valid FIFO entries; updates the cycle after push/pop.
// - Reset mid-operation discards FIFO contents and any output-slot data; no write is issued in the reset cycle or the following cycle.
// - Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSB differs && low bits equal.
// CONFIGURATION
// - REGFILE_WB_BYPASS_EN defined: adds ports id_rs1_addr/id_rs2_addr (in, 5), regfile_rs1_rdata/regfile_rs2_rdata (in, 32),
//   id_rs1_rdata/id_rs2_rdata (out, 32).
//   id_rsN_rdata = wb_rd_wdata when wb_q_is_rd_write && wb_rd_addr==id_rsN_addr && addr!=0, else regfile_rsN_rdata.
//   Purely combinational write-through.
// - Not defined: these ports are absent; ID reads the regfile directly (write visible the cycle after wb_*).
// STRUCTURE
// - Package regfile_wb_pkg: typedef struct packed wb_req_t {is_rd_write, rd_addr[4:0], rd_wdata[31:0]};
//   enum wb_state_e {WB_NORMAL, WB_DRAIN}; localparam REG_ADDR_W=5, XLEN=32.
// - Sub-module wb_fifo (sync FIFO of wb_req_t, FIFO_DEPTH entries, push/pop/full/empty, entry-valid vector for rd_busy_o).
// TESTING
// - MEM write x5=0xDEADBEEF, FIFO empty -> next cycle wb_q_is_rd_write=1, wb_rd_addr=5, wb_rd_wdata=0xDEADBEEF.
// - MDU write x7=0x11 while MEM is idle -> FIFO push, rd_busy_o[7]=1 for 1 cycle, then wb writes x7=0x11 and the busy bit clears.
// - Fill FIFO with 4 MDU results under continuous MEM writes -> mdu_ready_o=0; after 8 denials DRAIN:
//   mem_ready_o=0 for 1 cycle, one entry written.
// - MEM write x0=0x1234 -> mem_ready_o=1, wb_q_is_rd_write stays 0; MDU write x0 -> accepted, rd_busy_o unchanged.
// - rst_i pulsed with 3 FIFO entries -> rd_busy_o=0, mdu_ready_o=1, no wb write in the reset cycle or the cycle after.
// - REGFILE_WB_BYPASS_EN: wb writes x3=0xAA while id_rs1_addr=3 and regfile_rs1_rdata=0x00 -> id_rs1_rdata=0xAA;
//   id_rs2_addr=0 -> regfile_rs2_rdata passes through.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
//   Shared types and constants for the register-file write-back path.
//   wb_req_t   : one write request (enable, destination register, data)
//   wb_state_e : arbitration state of regfile_wb_writer (normal / forced drain)
//   reg_onehot : destination address -> one-hot register mask
package regfile_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic                  is_rd_write;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_wdata;
  } wb_req_t;

  typedef enum logic [0:0] {
    WB_NORMAL = 1'b0,
    WB_DRAIN  = 1'b1
  } wb_state_e;

  localparam wb_req_t WB_REQ_IDLE = '{is_rd_write: 1'b0, rd_addr: 5'd0, rd_wdata: 32'd0};

  // One-hot mask of a destination register, used to build the busy vector.
  function automatic logic [XLEN-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    reg_onehot = 32'd1 << addr;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo
//   Synchronous FIFO of wb_req_t holding long-latency (MDU) results until the
//   write port is free. Also reports which registers have a pending write.
// Ports
//   clk_i, rst_i   : clock, synchronous active-high reset (empties the FIFO)
//   push_i         : write push_data_i at the tail (ignored when full unless popping)
//   push_data_i    : request to store
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : current head entry
//   full_o/empty_o : occupancy flags, derived only from the pointer registers
//   busy_mask_o    : OR of one-hot(rd_addr) over all valid entries, bit 0 forced 0
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  wb_req_t         push_data_i,
  input  logic            pop_i,
  output wb_req_t         head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [XLEN-1:0] busy_mask_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  wb_req_t          store_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [XLEN-1:0]  busy_s;

  assign full_o  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                   (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign empty_o = (wr_ptr_r == rd_ptr_r);
  assign head_o  = store_r[rd_ptr_r[PTR_W-1:0]];

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign push_ok_s = push_i && (!full_o || pop_i);
  assign pop_ok_s  = pop_i && !empty_o;

  // Pointer, storage and entry-valid registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
      valid_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        store_r[i] <= WB_REQ_IDLE;
      end
    end else begin
      // Clear before set: on a full push+pop both hit the same slot and it must stay valid.
      if (pop_ok_s) begin
        rd_ptr_r                        <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
        valid_r[rd_ptr_r[PTR_W-1:0]]    <= 1'b0;
      end
      if (push_ok_s) begin
        wr_ptr_r                        <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
        valid_r[wr_ptr_r[PTR_W-1:0]]    <= 1'b1;
        store_r[wr_ptr_r[PTR_W-1:0]]    <= push_data_i;
      end
    end
  end

  // Busy mask: every register with a write still waiting in the FIFO.
  always_comb begin
    busy_s = {XLEN{1'b0}};
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_r[i]) begin
        busy_s = busy_s | reg_onehot(store_r[i].rd_addr);
      end else begin
        busy_s = busy_s;
      end
    end
    busy_s[0] = 1'b0;
  end

  assign busy_mask_o = busy_s;

endmodule

// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer
//   Write side of the 3-port register file. In-order MEM results have
//   priority for the single write slot; out-of-order MDU results wait in a
//   FIFO and are written whenever MEM leaves the slot free. If MEM keeps the
//   slot for STARVE_LIMIT consecutive cycles while the FIFO holds data, MEM
//   is stalled for one cycle (DRAIN) so the FIFO head can retire.
// Ports
//   clk_i, rst_i                          : clock, synchronous active-high reset
//   mem_valid_i / mem_ready_o             : MEM result handshake
//   mem_is_rd_write_i, mem_rd_addr_i, mem_rd_wdata_i : MEM result payload
//   mdu_valid_i / mdu_ready_o             : MDU result handshake (ready = FIFO not full)
//   mdu_rd_addr_i, mdu_rd_wdata_i         : MDU result payload
//   rd_busy_o                             : registers with a write pending in the FIFO
//   wb_q_is_rd_write, wb_rd_addr, wb_rd_wdata : registered regfile write port
// Optional build macro REGFILE_WB_BYPASS_EN
//   Adds id_rs1/rs2 address and regfile read-data inputs plus id_rs1/rs2
//   read-data outputs, forwarding the current wb write combinationally.
module regfile_wb_writer
  import regfile_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic                  mem_is_rd_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
  input  logic [XLEN-1:0]       mem_rd_wdata_i,
  input  logic                  mdu_valid_i,
  output logic                  mdu_ready_o,
  input  logic [REG_ADDR_W-1:0] mdu_rd_addr_i,
  input  logic [XLEN-1:0]       mdu_rd_wdata_i,
  output logic [XLEN-1:0]       rd_busy_o,
  output logic                  wb_q_is_rd_write,
  output logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic [XLEN-1:0]       wb_rd_wdata
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]       regfile_rs1_rdata,
  input  logic [XLEN-1:0]       regfile_rs2_rdata,
  output logic [XLEN-1:0]       id_rs1_rdata,
  output logic [XLEN-1:0]       id_rs2_rdata
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  wb_state_e       state_r;
  wb_state_e       state_nxt_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_nxt_s;
  wb_req_t         slot_r;
  wb_req_t         slot_nxt_s;

  logic            mem_ready_s;
  logic            mem_write_s;
  logic            deny_s;
  logic            fifo_push_s;
  logic            fifo_pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  wb_req_t         fifo_head_s;
  wb_req_t         mdu_req_s;
  logic [XLEN-1:0] busy_s;

  // MDU results aimed at x0 are accepted but never stored.
  assign mdu_req_s   = '{is_rd_write: 1'b1, rd_addr: mdu_rd_addr_i, rd_wdata: mdu_rd_wdata_i};
  assign fifo_push_s = mdu_valid_i && !fifo_full_s && (mdu_rd_addr_i != REG_X0);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push_s),
    .push_data_i (mdu_req_s),
    .pop_i       (fifo_pop_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .busy_mask_o (busy_s)
  );

  // State and starvation counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= WB_NORMAL;
      starve_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Next state: count MEM wins over a waiting FIFO and force one drain cycle at the limit.
  always_comb begin
    state_nxt_s      = state_r;
    starve_cnt_nxt_s = starve_cnt_r;
    case (state_r)
      WB_NORMAL: begin
        if (fifo_pop_s) begin
          starve_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (deny_s) begin
          if (starve_cnt_r == CNT_LAST) begin
            state_nxt_s = WB_DRAIN;
          end else begin
            starve_cnt_nxt_s = starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          starve_cnt_nxt_s = starve_cnt_r;
        end
      end
      WB_DRAIN: begin
        state_nxt_s      = WB_NORMAL;
        starve_cnt_nxt_s = {CNT_W{1'b0}};
      end
      default: begin
        state_nxt_s      = WB_NORMAL;
        starve_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Outputs of the arbiter: MEM ready, who owns the write slot, and FIFO pop.
  always_comb begin
    mem_ready_s = 1'b0;
    mem_write_s = 1'b0;
    deny_s      = 1'b0;
    fifo_pop_s  = 1'b0;
    case (state_r)
      WB_NORMAL: begin
        mem_ready_s = 1'b1;
        mem_write_s = mem_valid_i && mem_is_rd_write_i;
        deny_s      = mem_write_s && !fifo_empty_s;
        fifo_pop_s  = !mem_write_s && !fifo_empty_s;
      end
      WB_DRAIN: begin
        mem_ready_s = 1'b0;
        fifo_pop_s  = !fifo_empty_s;
      end
      default: begin
        mem_ready_s = 1'b0;
        fifo_pop_s  = 1'b0;
      end
    endcase
  end

  // Content of the write slot for the next cycle; x0 writes keep the enable low.
  always_comb begin
    slot_nxt_s = WB_REQ_IDLE;
    if (mem_write_s) begin
      slot_nxt_s.is_rd_write = (mem_rd_addr_i != REG_X0);
      slot_nxt_s.rd_addr     = mem_rd_addr_i;
      slot_nxt_s.rd_wdata    = mem_rd_wdata_i;
    end else if (fifo_pop_s) begin
      slot_nxt_s.is_rd_write = fifo_head_s.is_rd_write && (fifo_head_s.rd_addr != REG_X0);
      slot_nxt_s.rd_addr     = fifo_head_s.rd_addr;
      slot_nxt_s.rd_wdata    = fifo_head_s.rd_wdata;
    end else begin
      slot_nxt_s = WB_REQ_IDLE;
    end
  end

  // Registered write slot; a write is visible for exactly one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_r <= WB_REQ_IDLE;
    end else begin
      slot_r <= slot_nxt_s;
    end
  end

  assign mem_ready_o      = mem_ready_s;
  assign mdu_ready_o      = !fifo_full_s;
  assign rd_busy_o        = busy_s;
  assign wb_q_is_rd_write = slot_r.is_rd_write;
  assign wb_rd_addr       = slot_r.rd_addr;
  assign wb_rd_wdata      = slot_r.rd_wdata;

`ifdef REGFILE_WB_BYPASS_EN
  // Write-through forwarding of the in-flight regfile write to the ID read ports.
  always_comb begin
    id_rs1_rdata = regfile_rs1_rdata;
    id_rs2_rdata = regfile_rs2_rdata;
    if (slot_r.is_rd_write && (slot_r.rd_addr == id_rs1_addr) && (id_rs1_addr != REG_X0)) begin
      id_rs1_rdata = slot_r.rd_wdata;
    end else begin
      id_rs1_rdata = regfile_rs1_rdata;
    end
    if (slot_r.is_rd_write && (slot_r.rd_addr == id_rs2_addr) && (id_rs2_addr != REG_X0)) begin
      id_rs2_rdata = slot_r.rd_wdata;
    end else begin
      id_rs2_rdata = regfile_rs2_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_writer.sv
module tb_regfile_wb_writer;

  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_wr;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic [31:0] busy;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic [31:0] id_rs1;
  logic [31:0] id_rs2;
`endif

  int vectors;
  int miscompares;

  // Reference model: pending MDU writes in arrival order, denial count,
  // a pending drain cycle, and the write expected on the wb port.
  logic [4:0]  q_addr[$];
  logic [31:0] q_data[$];
  int          starve;
  bit          drain;
  bit          mem_acc;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  regfile_wb_writer #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .mem_valid_i       (mem_valid),
    .mem_ready_o       (mem_ready),
    .mem_is_rd_write_i (mem_wr),
    .mem_rd_addr_i     (mem_addr),
    .mem_rd_wdata_i    (mem_data),
    .mdu_valid_i       (mdu_valid),
    .mdu_ready_o       (mdu_ready),
    .mdu_rd_addr_i     (mdu_addr),
    .mdu_rd_wdata_i    (mdu_data),
    .rd_busy_o         (busy),
    .wb_q_is_rd_write  (wb_we),
    .wb_rd_addr        (wb_addr),
    .wb_rd_wdata       (wb_data)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .id_rs1_addr       (rs1_addr),
    .id_rs2_addr       (rs2_addr),
    .regfile_rs1_rdata (rf_rs1),
    .regfile_rs2_rdata (rf_rs2),
    .id_rs1_rdata      (id_rs1),
    .id_rs2_rdata      (id_rs2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = 32'd0;
    foreach (q_addr[i]) b = b | (32'd1 << q_addr[i]);
    return b;
  endfunction

  // Advance the model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    int sz;
    sz = q_addr.size();
    if (rst) begin
      q_addr.delete();
      q_data.delete();
      starve  = 0;
      drain   = 1'b0;
      mem_acc = 1'b0;
      e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    end else begin
      mem_acc = mem_valid && !drain;
      e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
      if (drain) begin
        if (sz > 0) begin
          e_we = 1'b1; e_addr = q_addr.pop_front(); e_data = q_data.pop_front();
        end
        drain  = 1'b0;
        starve = 0;
      end else if (mem_acc && mem_wr) begin
        e_we = (mem_addr != 5'd0); e_addr = mem_addr; e_data = mem_data;
        if (sz > 0) begin
          starve++;
          if (starve == STARVE_LIMIT) begin
            drain  = 1'b1;
            starve = 0;
          end
        end
      end else if (sz > 0) begin
        e_we = 1'b1; e_addr = q_addr.pop_front(); e_data = q_data.pop_front();
        starve = 0;
      end
      if (mdu_valid && (sz < FIFO_DEPTH) && (mdu_addr != 5'd0)) begin
        q_addr.push_back(mdu_addr);
        q_data.push_back(mdu_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_wr = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors += 4;
    if (wb_we !== 1'b0) begin miscompares++; $display("FAIL reset_wb_we got=%0b exp=0", wb_we); end
    if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mem_ready got=%0b exp=1", mem_ready); end
    if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL reset_mdu_ready got=%0b exp=1", mdu_ready); end
    if (busy !== 32'd0) begin miscompares++; $display("FAIL reset_busy got=%h exp=0", busy); end
  endtask

  task automatic test_mem_write();
    do_reset();
    mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 5'd5; mem_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    vectors++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL mem_write got=%0b/%0d/%h exp=1/5/deadbeef", wb_we, wb_addr, wb_data);
    end
    tick();
    vectors++;
    if (wb_we !== 1'b0) begin miscompares++; $display("FAIL mem_write_hold got=%0b exp=0", wb_we); end
  endtask

  task automatic test_mdu_write();
    do_reset();
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'h11;
    tick();
    idle_inputs();
    vectors++;
    if (busy !== 32'h80 || wb_we !== 1'b0) begin
      miscompares++; $display("FAIL mdu_queued got busy=%h we=%0b exp busy=00000080 we=0", busy, wb_we);
    end
    tick();
    vectors++;
    if (wb_we !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'h11 || busy !== 32'd0) begin
      miscompares++;
      $display("FAIL mdu_write got=%0b/%0d/%h busy=%h exp=1/7/00000011 busy=0", wb_we, wb_addr, wb_data, busy);
    end
  endtask

  task automatic test_x0();
    do_reset();
    mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 5'd0; mem_data = 32'h1234;
    vectors++;
    if (mem_ready !== 1'b1) begin miscompares++; $display("FAIL x0_mem_ready got=%0b exp=1", mem_ready); end
    tick();
    idle_inputs();
    vectors++;
    if (wb_we !== 1'b0) begin miscompares++; $display("FAIL x0_mem_we got=%0b exp=0", wb_we); end
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h99;
    vectors++;
    if (mdu_ready !== 1'b1) begin miscompares++; $display("FAIL x0_mdu_ready got=%0b exp=1", mdu_ready); end
    tick();
    idle_inputs();
    vectors++;
    if (busy !== 32'd0) begin miscompares++; $display("FAIL x0_mdu_busy got=%h exp=0", busy); end
    tick();
    vectors++;
    if (wb_we !== 1'b0) begin miscompares++; $display("FAIL x0_mdu_we got=%0b exp=0", wb_we); end
  endtask

  task automatic test_starve_drain();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      mem_valid = 1'b1; mem_wr = 1'b1;
      if (c == 0 || mem_acc) begin
        mem_addr = 5'(c + 1);
        mem_data = 32'h1000 + 32'(c);
      end
      mdu_valid = (c < 4);
      mdu_addr  = 5'(10 + c);
      mdu_data  = 32'h2000 + 32'(c);
      vectors++;
      if (mem_ready !== ((c == 9) ? 1'b0 : 1'b1)) begin
        miscompares++; $display("FAIL starve_mem_ready cycle=%0d got=%0b exp=%0b", c, mem_ready, (c != 9));
      end
      if (c == 4) begin
        vectors++;
        if (mdu_ready !== 1'b0) begin miscompares++; $display("FAIL starve_full got=%0b exp=0", mdu_ready); end
      end
      if (c == 10) begin
        vectors++;
        if (wb_we !== 1'b1 || wb_addr !== 5'd10 || wb_data !== 32'h2000) begin
          miscompares++;
          $display("FAIL drain_write got=%0b/%0d/%h exp=1/10/00002000", wb_we, wb_addr, wb_data);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 5'(1 + c); mem_data = 32'(c);
      mdu_valid = 1'b1; mdu_addr = 5'(20 + c); mdu_data = 32'h300 + 32'(c);
      tick();
    end
    idle_inputs();
    vectors++;
    if (busy !== 32'h0070_0000) begin miscompares++; $display("FAIL mid_busy_before got=%h exp=00700000", busy); end
    rst = 1'b1;
    tick();
    vectors++;
    if (busy !== 32'd0 || mdu_ready !== 1'b1 || wb_we !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset got busy=%h mdu_ready=%0b we=%0b exp 0/1/0", busy, mdu_ready, wb_we);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (wb_we !== 1'b0 || busy !== 32'd0) begin
      miscompares++; $display("FAIL mid_after got we=%0b busy=%h exp 0/0", wb_we, busy);
    end
  endtask

`ifdef REGFILE_WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    mem_valid = 1'b1; mem_wr = 1'b1; mem_addr = 5'd3; mem_data = 32'hAA;
    tick();
    idle_inputs();
    rs1_addr = 5'd3; rf_rs1 = 32'h0;
    rs2_addr = 5'd0; rf_rs2 = 32'h55;
    #1;
    vectors += 2;
    if (id_rs1 !== 32'hAA) begin miscompares++; $display("FAIL bypass_rs1 got=%h exp=000000aa", id_rs1); end
    if (id_rs2 !== 32'h55) begin miscompares++; $display("FAIL bypass_rs2 got=%h exp=00000055", id_rs2); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mem_valid = ($urandom_range(0, 9) < 8);
      mem_wr    = ($urandom_range(0, 7) != 0);
      mem_addr  = 5'($urandom_range(0, 31));
      mem_data  = $urandom();
      mdu_valid = ($urandom_range(0, 9) < 4);
      mdu_addr  = 5'($urandom_range(0, 31));
      mdu_data  = $urandom();
      vectors += 4;
      if (mem_ready !== !drain) begin
        miscompares++; $display("FAIL rnd_mem_ready cycle=%0d got=%0b exp=%0b", c, mem_ready, !drain);
      end
      if (mdu_ready !== (q_addr.size() < FIFO_DEPTH)) begin
        miscompares++; $display("FAIL rnd_mdu_ready cycle=%0d got=%0b exp=%0b", c, mdu_ready, (q_addr.size() < FIFO_DEPTH));
      end
      if (busy !== model_busy()) begin
        miscompares++; $display("FAIL rnd_busy cycle=%0d got=%h exp=%h", c, busy, model_busy());
      end
      if (wb_we !== e_we) begin
        miscompares++; $display("FAIL rnd_wb_we cycle=%0d got=%0b exp=%0b", c, wb_we, e_we);
      end
      if (e_we) begin
        vectors++;
        if (wb_addr !== e_addr || wb_data !== e_data) begin
          miscompares++; $display("FAIL rnd_wb_data cycle=%0d got=%0d/%h exp=%0d/%h", c, wb_addr, wb_data, e_addr, e_data);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    starve      = 0;
    drain       = 1'b0;
    mem_acc     = 1'b0;
    e_we = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    rst = 1'b1;
    idle_inputs();
`ifdef REGFILE_WB_BYPASS_EN
    rs1_addr = 5'd0; rs2_addr = 5'd0; rf_rs1 = 32'd0; rf_rs2 = 32'd0;
`endif
    test_reset();
    test_mem_write();
    test_mdu_write();
    test_x0();
    test_starve_drain();
    test_reset_mid();
`ifdef REGFILE_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
